wb_freq_meter: RTL and testbench

Measures the frequency and period of an external square-wave input against `wb_clk_i`, so that clocks produced by the design's clock-generation blocks, or clocks brought in from off-chip, can be checked at run time. It samples `clock_in` through a two-flop synchronizer and counts rising edges over a fixed gate window. It also measures the `wb_clk_i` tick count between consecutive rising edges. Results are read by the CPU over a Wishbone B4 classic slave port.

---
 rtl/wb_freq_meter.sv | 182 ++++++++++++++++++
 tb/tb_wb_freq_meter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_freq_meter.sv
// wb_freq_meter
//   Measures an external square wave against wb_clk_i. Counts rising
//   edges of clock_in over a fixed gate window (COUNT) and the number of
//   wb_clk_i ticks between consecutive rising edges (PERIOD). Results are
//   read over a Wishbone B4 classic slave port.
//
//   Register map (word address):
//     0 CTRL   : bit0 enable (RW), bit1 clear (write-1, self-clearing, reads 0)
//     1 STATUS : bit0 valid (RO), bit1 count_ovf (W1C), bit2 period_sat (W1C)
//     2 COUNT  : rising edges in the last completed window (RO)
//     3 PERIOD : wb_clk_i ticks between the last two rising edges (RO)
//
//   Ports:
//     wb_clk_i, wb_rst_ni        : system clock, async active-low reset
//     wb_cyc_i, wb_stb_i,
//     wb_we_i, wb_adr_i[1:0],
//     wb_dat_i[31:0]             : Wishbone slave request
//     wb_dat_o[31:0], wb_ack_o   : Wishbone slave response (one-cycle ack)
//     clock_in                   : signal under measurement (asynchronous)
module wb_freq_meter #(
    parameter int WB_CLK_HZ = 12_000_000,
    parameter int GATE_HZ   = 1000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        clock_in
);

    localparam int          GATE_TICKS = WB_CLK_HZ / GATE_HZ;
    localparam logic [31:0] GATE_LAST  = 32'(GATE_TICKS - 1);
    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

    typedef enum logic {ST_IDLE, ST_GATING} state_t;

    state_t      state_q, state_d;
    logic        sync1, sync2, sync3, rise;
    logic        enable_q, valid_q, count_ovf_q, period_sat_q, armed_q;
    logic [31:0] gate_q, edge_q, period_cnt_q, count_q, period_q;
    logic        bus_req, ctrl_wr, stat_wr, clear;
    logic        gating, win_close, ovf_evt, sat_evt;
    logic [31:0] rd_data;
    logic        unused_dat_bits;

    assign unused_dat_bits = ^wb_dat_i[31:3];

    // The ack term keeps a held strobe from being accepted twice, which
    // gives the one-cycle ack and the every-second-cycle back-to-back rate.
    assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign ctrl_wr = bus_req & wb_we_i & (wb_adr_i == 2'd0);
    assign stat_wr = bus_req & wb_we_i & (wb_adr_i == 2'd1);
    assign clear   = ctrl_wr & wb_dat_i[1];

    // Two-flop synchronizer plus a third flop for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real flops do.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= clock_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    assign gating    = (state_q == ST_GATING);
    assign win_close = gating && (gate_q == GATE_LAST);
    // A clear zeroes the counters in the same cycle, so it also masks the
    // saturation events that the old counter values would have raised.
    assign ovf_evt   = gating && !clear && rise && (edge_q == CNT_MAX);
    assign sat_evt   = gating && !clear && !rise && (period_cnt_q == CNT_MAX);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first, so every path assigns state_d and no latch
        // is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (enable_q)  state_d = ST_GATING;
            ST_GATING: if (!enable_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control and sticky flags. A new saturation event wins over a
    // simultaneous write-1-to-clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            enable_q     <= 1'b0;
            count_ovf_q  <= 1'b0;
            period_sat_q <= 1'b0;
        end else begin
            if (ctrl_wr) enable_q <= wb_dat_i[0];
            count_ovf_q  <= (count_ovf_q  & ~(stat_wr & wb_dat_i[1])) | ovf_evt;
            period_sat_q <= (period_sat_q & ~(stat_wr & wb_dat_i[2])) | sat_evt;
        end
    end

    // Gate window, edge counter and period counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            gate_q       <= '0;
            edge_q       <= '0;
            period_cnt_q <= '0;
            armed_q      <= 1'b0;
            count_q      <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
        end else if (clear) begin
            gate_q       <= '0;
            edge_q       <= '0;
            period_cnt_q <= '0;
            armed_q      <= 1'b0;
            count_q      <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
        end else if (!gating) begin
            gate_q       <= '0;
            edge_q       <= '0;
            period_cnt_q <= '0;
            armed_q      <= 1'b0;
        end else begin
            gate_q <= win_close ? '0 : gate_q + 32'd1;

            // An edge on the closing cycle belongs to the closing window.
            if (win_close) begin
                count_q <= (edge_q == CNT_MAX) ? CNT_MAX : edge_q + 32'(rise);
                edge_q  <= '0;
                valid_q <= 1'b1;
            end else if (rise && edge_q != CNT_MAX) begin
                edge_q  <= edge_q + 32'd1;
            end

            // The counter reads ticks since the last edge minus one, hence +1.
            if (rise) begin
                if (armed_q)
                    period_q <= (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + 32'd1;
                period_cnt_q <= '0;
                armed_q      <= 1'b1;
            end else if (period_cnt_q != CNT_MAX) begin
                period_cnt_q <= period_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            2'd0: rd_data = {31'd0, enable_q};
            2'd1: rd_data = {29'd0, period_sat_q, count_ovf_q, valid_q};
            2'd2: rd_data = count_q;
            2'd3: rd_data = period_q;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_req;
            if (bus_req && !wb_we_i) wb_dat_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_wb_freq_meter.sv
// Bench for wb_freq_meter with a 20-tick gate window (100 Hz / 5 Hz).
// A time-stamp based model predicts every bus response; directed tests pin
// the model with hand-computed values.
module tb_wb_freq_meter;

    localparam int          GT  = 20;
    localparam longint      MAX = 64'hFFFF_FFFF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we_r = 1'b0;
    logic [1:0]  adr_r = '0;
    logic [31:0] dat_r = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        clock_in = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    wb_freq_meter #(.WB_CLK_HZ(100), .GATE_HZ(5)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we_r),
        .wb_adr_i (adr_r),
        .wb_dat_i (dat_r),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .clock_in (clock_in)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // clock_in driver: periodic pattern or a manual level
    bit pat_on = 0;
    int pat_hi = 2, pat_lo = 3, pat_ph = 0;
    bit man_lvl = 0;

    initial forever begin
        @(negedge wb_clk_i);
        if (pat_on) begin
            clock_in = (pat_ph < pat_hi);
            pat_ph   = (pat_ph + 1 == pat_hi + pat_lo) ? 0 : pat_ph + 1;
        end else begin
            clock_in = man_lvl;
        end
    end

    // Model: time stamps instead of counters. t is the index of the next edge.
    longint      t = 0;
    longint      force_at_t = -1;
    longint      force_val  = 0;
    bit [3:0]    hist;
    bit          m_en, m_gating, m_armed, m_valid, m_ovf, m_sat, m_ack, m_rd;
    longint      m_win_start, m_ref, m_win_edges;
    logic [31:0] m_count, m_period, m_rdata;

    task automatic model_reset();
        t = 0; hist = '0;
        m_en = 0; m_gating = 0; m_armed = 0; m_valid = 0; m_ovf = 0; m_sat = 0;
        m_ack = 0; m_rd = 0; m_win_start = 0; m_ref = 0; m_win_edges = 0;
        m_count = '0; m_period = '0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit          rise, acc, wr_ctrl, wr_stat, clr, ovf_evt, sat_evt, next_gating;
        longint      pc;
        logic [31:0] rd;
        rise    = hist[1] & ~hist[2];
        acc     = cyc & stb & ~m_ack;
        wr_ctrl = acc & we_r & (adr_r == 2'd0);
        wr_stat = acc & we_r & (adr_r == 2'd1);
        clr     = wr_ctrl & dat_r[1];
        ovf_evt = 0; sat_evt = 0;
        if (t == force_at_t) m_ref = t - force_val;
        pc = t - m_ref;
        if (pc > MAX) pc = MAX;
        case (adr_r)
            2'd0:    rd = {31'd0, m_en};
            2'd1:    rd = {29'd0, m_sat, m_ovf, m_valid};
            2'd2:    rd = m_count;
            default: rd = m_period;
        endcase
        if (clr || !m_gating) begin
            m_win_start = t + 1; m_ref = t + 1; m_armed = 0; m_win_edges = 0;
            if (clr) begin m_count = '0; m_period = '0; m_valid = 0; end
        end else begin
            if (t - m_win_start == GT - 1) begin
                if (m_win_edges == MAX && rise) ovf_evt = 1;
                m_count     = 32'((m_win_edges + rise > MAX) ? MAX : m_win_edges + rise);
                m_win_edges = 0;
                m_valid     = 1;
                m_win_start = t + 1;
            end else if (rise) begin
                if (m_win_edges == MAX) ovf_evt = 1;
                else m_win_edges++;
            end
            if (rise) begin
                if (m_armed) m_period = 32'((pc + 1 > MAX) ? MAX : pc + 1);
                m_ref = t + 1; m_armed = 1;
            end else if (pc == MAX) begin
                sat_evt = 1;
            end
        end
        if (wr_stat && dat_r[1]) m_ovf = 0;
        if (wr_stat && dat_r[2]) m_sat = 0;
        if (ovf_evt) m_ovf = 1;
        if (sat_evt) m_sat = 1;
        next_gating = m_en;
        if (wr_ctrl) m_en = dat_r[0];
        m_gating = next_gating;
        m_ack = acc;
        m_rd  = acc & ~we_r;
        if (acc && !we_r) m_rdata = rd;
        hist = {hist[2:0], clock_in};
        t++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge wb_clk_i or negedge wb_rst_ni);
            if (!wb_rst_ni) model_reset();
            else model_step();
        end
    end

    // Compare process: ack every cycle, data on every read ack.
    initial forever begin
        @(negedge wb_clk_i);
        if (wb_rst_ni) begin
            check("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
            if (m_ack && m_rd) check("rdata", wb_dat_o, m_rdata);
        end
    end

    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                       output logic [31:0] rdat);
        bit got = 0;
        @(negedge wb_clk_i);
        cyc = 1; stb = 1; we_r = we; adr_r = adr; dat_r = dat;
        rdat = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge wb_clk_i);
            if (wb_ack_o) begin got = 1; rdat = wb_dat_o; end
        end
        cyc = 0; stb = 0; we_r = 0;
        if (!got) check("bus_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        bus(1'b1, adr, dat, d);
    endtask

    task automatic rd_lit(input string name, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        bus(1'b0, adr, 0, d);
        check(name, d, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(5);
        wb_rst_ni = 1'b1;
        wait_cyc(2);

        // Reset values and one-cycle ack
        for (int a = 0; a < 4; a++) begin
            rd_lit("reset_read", 2'(a), 32'd0);
            @(negedge wb_clk_i);
            check("ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
        end

        // 2 high / 3 low: 4 edges per 20-tick window, period 5
        pat_hi = 2; pat_lo = 3; pat_ph = 0; pat_on = 1;
        wr(2'd0, 32'd1);
        rd_lit("ctrl_enabled", 2'd0, 32'd1);
        wait_cyc(45);
        rd_lit("status_valid", 2'd1, 32'd1);
        rd_lit("count_p5", 2'd2, 32'd4);
        rd_lit("period_p5", 2'd3, 32'd5);
        for (int i = 0; i < 5; i++) begin
            wait_cyc(10);
            rd_lit("count_p5_loop", 2'd2, 32'd4);
        end

        // Period 7 drifts against the window, so edges land on every window
        // position including the close cycle; the model checks each read.
        pat_hi = 3; pat_lo = 4; pat_ph = 0;
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            wait_cyc(5);
            bus(1'b0, 2'd2, 0, d);
        end
        rd_lit("period_p7", 2'd3, 32'd7);

        // Disable mid-window, re-enable: old results held, first edge only arms
        pat_hi = 2; pat_lo = 3; pat_ph = 0;
        wait_cyc(50);
        rd_lit("count_before_disable", 2'd2, 32'd4);
        wait_cyc(7);
        wr(2'd0, 32'd0);
        pat_on = 0; man_lvl = 0;
        wait_cyc(30);
        rd_lit("count_held_idle", 2'd2, 32'd4);
        rd_lit("period_held_idle", 2'd3, 32'd5);
        rd_lit("status_held_idle", 2'd1, 32'd1);
        wr(2'd0, 32'd1);
        man_lvl = 1; wait_cyc(3);
        man_lvl = 0; wait_cyc(5);
        rd_lit("count_after_reenable", 2'd2, 32'd4);
        rd_lit("period_first_edge_arms", 2'd3, 32'd5);
        pat_hi = 2; pat_lo = 2; pat_ph = 0; pat_on = 1;
        wait_cyc(60);
        rd_lit("count_p4", 2'd2, 32'd5);
        rd_lit("period_p4", 2'd3, 32'd4);

        // Clear + enable while running
        wr(2'd0, 32'd3);
        rd_lit("period_cleared", 2'd3, 32'd0);
        rd_lit("status_cleared", 2'd1, 32'd0);
        rd_lit("count_cleared", 2'd2, 32'd0);
        rd_lit("ctrl_clear_reads0", 2'd0, 32'd1);
        wait_cyc(25);
        rd_lit("status_valid_again", 2'd1, 32'd1);

        // Period counter saturation: hold clock_in, preload counter near max
        pat_on = 0; man_lvl = 0;
        wait_cyc(10);
        force_val  = 64'hFFFF_FFF0;
        force_at_t = t;
        force dut.period_cnt_q = 32'hFFFF_FFF0;
        @(negedge wb_clk_i);
        release dut.period_cnt_q;
        wait_cyc(40);
        rd_lit("period_sat_set", 2'd1, 32'd5);
        wr(2'd0, 32'd0);
        rd_lit("period_sat_sticky", 2'd1, 32'd5);
        wr(2'd1, 32'd4);
        rd_lit("period_sat_w1c", 2'd1, 32'd1);

        // Writes to read-only registers are ignored
        wr(2'd2, 32'hFFFF_FFFF);
        rd_lit("count_ro", 2'd2, 32'd0);
        rd_lit("ctrl_disabled", 2'd0, 32'd0);

        wait_cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
